// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding, status word layout
// and trigger counter width.
package reset_seq_pkg;

    localparam logic [1:0] SEQ_IDLE  = 2'd0;
    localparam logic [1:0] SEQ_ARMED = 2'd1;
    localparam logic [1:0] SEQ_RUN   = 2'd2;
    localparam logic [1:0] SEQ_FAULT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = SEQ_IDLE,
        ST_ARMED = SEQ_ARMED,
        ST_RUN   = SEQ_RUN,
        ST_FAULT = SEQ_FAULT
    } seq_state_t;

    localparam int STATUS_STATE_LSB = 0;
    localparam int STATUS_TRIG_S    = 2;
    localparam int STATUS_WDOG_S    = 3;
    localparam int STATUS_INST_S    = 4;
    localparam int STATUS_WD_FLT    = 5;
    localparam int STATUS_INST_FLT  = 6;
    localparam int STATUS_SOFT_S    = 7;
    localparam int STATUS_CH_LSB    = 8;
    localparam int STATUS_CNT_LSB   = 16;

    localparam int TRIG_CNT_W = 16;

endpackage

// File: rtl/reset_sequencer_if.sv
// Config/status register bus between the PS register block (master) and the sequencer (slave).
interface reset_sequencer_if #(
    parameter int NUM_CH     = 4,
    parameter int TRIG_SEL_W = 2,
    parameter int WD_W       = 28
);
    logic                  cfg_arm;
    logic [NUM_CH-1:0]     cfg_mode;
    logic [TRIG_SEL_W-1:0] cfg_trig_sel;
    logic                  cfg_trig_level;
    logic                  cfg_instant_en;
    logic [WD_W-1:0]       cfg_wd_timeout;
    logic                  reset_ack;
    logic [1:0]            seq_state;
    logic [31:0]           status;

    modport master (
        output cfg_arm, cfg_mode, cfg_trig_sel, cfg_trig_level, cfg_instant_en, cfg_wd_timeout,
        input  reset_ack, seq_state, status
    );

    modport slave (
        input  cfg_arm, cfg_mode, cfg_trig_sel, cfg_trig_level, cfg_instant_en, cfg_wd_timeout,
        output reset_ack, seq_state, status
    );
endinterface

// File: rtl/reset_seq_sync.sv
// Vector synchroniser: STAGES flops per bit, cleared asynchronously by areset.
module reset_seq_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             areset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [STAGES-1:0][WIDTH-1:0] stage_reg;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= {stage_reg[STAGES-2:0], d};
        end
    end

    assign q = stage_reg[STAGES-1];
endmodule

// File: rtl/reset_sequencer.sv
// Arm/trigger/fault sequencer driving NUM_CH peripheral resets.
// Define RESET_SEQ_WATCHDOG_EN to build the watchdog timeout counter and fault.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int NUM_TRIG_SRC = 4,
    parameter int TRIG_SEL_W   = 2,
    parameter int SYNC_STAGES  = 2,
    parameter int WD_W         = 28,
    parameter int ALIVE_LOW    = 12500000,
    parameter int ALIVE_HIGH   = 1250000
) (
    input  logic                    clk,
    input  logic                    areset,
    input  logic                    soft_resetn,
    input  logic [NUM_TRIG_SRC-1:0] trig_src,
    input  logic                    instant_reset,
    input  logic                    watchdog,
    output logic [NUM_CH-1:0]       ch_aresetn,
    output logic                    alive_signal,
    reset_sequencer_if.slave        regs
);
    localparam int SW       = NUM_TRIG_SRC + 3;
    localparam int ALIVE_P  = ALIVE_LOW + ALIVE_HIGH;
    localparam int ALIVE_CW = (ALIVE_P > 1) ? $clog2(ALIVE_P) : 1;

    logic [SW-1:0]           sync_out;
    logic [NUM_TRIG_SRC-1:0] trig_vec;
    logic instant_s, watchdog_s, soft_resetn_s, trig_s, trig_rise, instant_hit, wd_hit;

    seq_state_t              state_reg, state_next;
    logic                    trig_prev_reg;
    logic [TRIG_CNT_W-1:0]   trig_cnt_reg;
    logic                    wd_flt_reg, inst_flt_reg, reset_ack_reg, alive_reg;
    logic [NUM_CH-1:0]       ch_aresetn_reg;
    logic [ALIVE_CW-1:0]     alive_cnt_reg;
    logic [7:0]              ch_status;
    logic [31:0]             status_w;

    reset_seq_sync #(.WIDTH(SW), .STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .areset (areset),
        .d      ({soft_resetn, watchdog, instant_reset, trig_src}),
        .q      (sync_out)
    );

    assign trig_vec      = sync_out[NUM_TRIG_SRC-1:0];
    assign instant_s     = sync_out[NUM_TRIG_SRC];
    assign watchdog_s    = sync_out[NUM_TRIG_SRC+1];
    assign soft_resetn_s = sync_out[NUM_TRIG_SRC+2];

    // Select values with no matching source read as a constant-low trigger.
    always_comb begin
        trig_s = 1'b0;
        if (int'(regs.cfg_trig_sel) < NUM_TRIG_SRC) trig_s = trig_vec[regs.cfg_trig_sel];
    end

    assign trig_rise   = trig_s & ~trig_prev_reg;
    assign instant_hit = regs.cfg_instant_en & instant_s;

`ifdef RESET_SEQ_WATCHDOG_EN
    logic [WD_W-1:0] wd_cnt_reg;
    logic            wd_prev_reg;

    // Any toggle of the synchronised watchdog input restarts the timeout.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            wd_cnt_reg  <= '0;
            wd_prev_reg <= 1'b0;
        end else begin
            wd_prev_reg <= watchdog_s;
            if (!soft_resetn_s || state_reg != ST_RUN || watchdog_s != wd_prev_reg)
                wd_cnt_reg <= '0;
            else if (wd_cnt_reg != '1)
                wd_cnt_reg <= wd_cnt_reg + 1'b1;
        end
    end

    assign wd_hit = (state_reg == ST_RUN) && (regs.cfg_wd_timeout != '0)
                    && (wd_cnt_reg == regs.cfg_wd_timeout);
`else
    logic unused_wd;
    assign unused_wd = ^regs.cfg_wd_timeout;
    assign wd_hit    = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        if (!soft_resetn_s) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:  if (regs.cfg_arm) state_next = ST_ARMED;
                ST_ARMED: begin
                    if (!regs.cfg_arm)                  state_next = ST_IDLE;
                    else if (trig_rise && !instant_hit) state_next = ST_RUN;
                end
                ST_RUN: begin
                    if (!regs.cfg_arm)                         state_next = ST_IDLE;
                    else if (instant_hit || wd_hit)            state_next = ST_FAULT;
                    else if (regs.cfg_trig_level && !trig_s)   state_next = ST_ARMED;
                end
                default:  if (!regs.cfg_arm) state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_reg      <= ST_IDLE;
            reset_ack_reg  <= 1'b0;
            trig_prev_reg  <= 1'b0;
            ch_aresetn_reg <= '0;
            trig_cnt_reg   <= '0;
            wd_flt_reg     <= 1'b0;
            inst_flt_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            reset_ack_reg  <= (state_next == ST_FAULT);
            trig_prev_reg  <= trig_s;
            ch_aresetn_reg <= soft_resetn_s ? (~regs.cfg_mode | {NUM_CH{state_reg == ST_RUN}}) : '0;
            if (!soft_resetn_s) begin
                trig_cnt_reg <= '0;
                wd_flt_reg   <= 1'b0;
                inst_flt_reg <= 1'b0;
            end else if (state_reg == ST_ARMED && state_next == ST_RUN) begin
                if (trig_cnt_reg != '1) trig_cnt_reg <= trig_cnt_reg + 1'b1;
                wd_flt_reg   <= 1'b0;
                inst_flt_reg <= 1'b0;
            end else if (state_reg == ST_RUN && state_next == ST_FAULT) begin
                if (instant_hit)  inst_flt_reg <= 1'b1;
                else if (wd_hit)  wd_flt_reg   <= 1'b1;
            end
        end
    end

    // The output lags the counter by one cycle, which keeps the period exact.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            alive_cnt_reg <= '0;
            alive_reg     <= 1'b0;
        end else begin
            alive_reg <= (alive_cnt_reg >= ALIVE_CW'(ALIVE_LOW));
            if (alive_cnt_reg == ALIVE_CW'(ALIVE_P - 1)) alive_cnt_reg <= '0;
            else                                         alive_cnt_reg <= alive_cnt_reg + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_ch_status
            if (gi < NUM_CH) begin : g_used
                assign ch_status[gi] = ch_aresetn_reg[gi];
            end else begin : g_pad
                assign ch_status[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        status_w = '0;
        status_w[STATUS_STATE_LSB +: 2]        = state_reg;
        status_w[STATUS_TRIG_S]                = trig_s;
        status_w[STATUS_WDOG_S]                = watchdog_s;
        status_w[STATUS_INST_S]                = instant_s;
        status_w[STATUS_WD_FLT]                = wd_flt_reg;
        status_w[STATUS_INST_FLT]              = inst_flt_reg;
        status_w[STATUS_SOFT_S]                = soft_resetn_s;
        status_w[STATUS_CH_LSB +: 8]           = ch_status;
        status_w[STATUS_CNT_LSB +: TRIG_CNT_W] = trig_cnt_reg;
    end

    assign ch_aresetn     = ch_aresetn_reg;
    assign alive_signal   = alive_reg;
    assign regs.reset_ack = reset_ack_reg;
    assign regs.seq_state = state_reg;
    assign regs.status    = status_w;
endmodule
